// File: rtl/kernel_led_ctrl.sv
// Avalon-MM LED/GPIO output controller: static data with atomic set/clear,
// per-channel hardware blink from a programmable prescaler, and a global PWM brightness gate.
module kernel_led_ctrl #(
   parameter int WIDTH         = 4,
   parameter int PRESCALE_W    = 24,
   parameter int PRESCALE_INIT = 499999
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [2:0]             address,
   input  logic                   chipselect,
   input  logic                   write_n,
   input  logic [31:0]            writedata,
   output logic [31:0]            readdata,
   output logic [WIDTH-1:0]       out_port
);

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_MODE     = 3'd1;
   localparam logic [2:0] ADDR_PRESCALE = 3'd2;
   localparam logic [2:0] ADDR_BRIGHT   = 3'd3;
   localparam logic [2:0] ADDR_OUTSET   = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
   localparam logic [2:0] ADDR_STATUS   = 3'd6;

   localparam logic [PRESCALE_W-1:0] PRE_ONE   = PRESCALE_W'(1);
   localparam logic [PRESCALE_W-1:0] PRE_RESET = PRESCALE_W'(PRESCALE_INIT);

   logic [WIDTH-1:0]      data_q, data_d;
   logic [WIDTH-1:0]      mode_q, mode_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [7:0]            bright_q, bright_d;
   logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic                  blink_phase_q, blink_phase_d;
   logic [7:0]            pwm_cnt_q, pwm_cnt_d;
   logic [WIDTH-1:0]      out_port_q, out_port_d;

   logic             wr_en;
   logic [WIDTH-1:0] wd_ch;
   logic             pwm_on;

   assign wr_en  = chipselect & ~write_n;
   assign wd_ch  = writedata[WIDTH-1:0];
   assign pwm_on = (bright_q == 8'hFF) | (pwm_cnt_q < bright_q);

   // NOTE: every next-state signal is given a default at the top of the block so no latch is inferred.
   always_comb begin
      data_d        = data_q;
      mode_d        = mode_q;
      prescale_d    = prescale_q;
      bright_d      = bright_q;
      pre_cnt_d     = pre_cnt_q + PRE_ONE;
      blink_phase_d = blink_phase_q;
      pwm_cnt_d     = pwm_cnt_q + 8'd1;

      if (pre_cnt_q == prescale_q) begin
         pre_cnt_d     = '0;
         blink_phase_d = ~blink_phase_q;
      end

      if (wr_en) begin
         unique case (address)
            ADDR_DATA:     data_d   = wd_ch;
            ADDR_MODE:     mode_d   = wd_ch;
            ADDR_PRESCALE: begin
               // Restart the blink cycle so a lowered terminal count never has to wrap.
               prescale_d    = writedata[PRESCALE_W-1:0];
               pre_cnt_d     = '0;
               blink_phase_d = 1'b0;
            end
            ADDR_BRIGHT:   bright_d = writedata[7:0];
            ADDR_OUTSET:   data_d   = data_q | wd_ch;
            ADDR_OUTCLEAR: data_d   = data_q & ~wd_ch;
            default:       ;
         endcase
      end

      // Output uses current register values, giving one cycle of latency after a write.
      out_port_d = data_q & (~mode_q | {WIDTH{blink_phase_q}}) & {WIDTH{pwm_on}};
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q        <= '0;
         mode_q        <= '0;
         prescale_q    <= PRE_RESET;
         bright_q      <= 8'hFF;
         pre_cnt_q     <= '0;
         blink_phase_q <= 1'b0;
         pwm_cnt_q     <= '0;
         out_port_q    <= '0;
      end else begin
         data_q        <= data_d;
         mode_q        <= mode_d;
         prescale_q    <= prescale_d;
         bright_q      <= bright_d;
         pre_cnt_q     <= pre_cnt_d;
         blink_phase_q <= blink_phase_d;
         pwm_cnt_q     <= pwm_cnt_d;
         out_port_q    <= out_port_d;
      end
   end

   always_comb begin
      readdata = '0;
      unique case (address)
         ADDR_DATA:     readdata[WIDTH-1:0]      = data_q;
         ADDR_MODE:     readdata[WIDTH-1:0]      = mode_q;
         ADDR_PRESCALE: readdata[PRESCALE_W-1:0] = prescale_q;
         ADDR_BRIGHT:   readdata[7:0]            = bright_q;
         ADDR_STATUS:   readdata[0]              = blink_phase_q;
         default:       ;
      endcase
   end

   assign out_port = out_port_q;

endmodule

// File: tb/tb_kernel_led_ctrl.sv
// Directed testbench for kernel_led_ctrl (WIDTH=4, PRESCALE_W=24, PRESCALE_INIT=499999).
module tb_kernel_led_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [3:0]  out_port;

   int checks = 0;
   int errors = 0;

   kernel_led_ctrl #(
      .WIDTH(4),
      .PRESCALE_W(24),
      .PRESCALE_INIT(499999)
   ) dut (
      .clk(clk),
      .reset(reset),
      .address(address),
      .chipselect(chipselect),
      .write_n(write_n),
      .writedata(writedata),
      .readdata(readdata),
      .out_port(out_port)
   );

   always #5 clk = ~clk;

   // Write lands on the next rising edge; returns 1 time unit after that edge.
   task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] exp_rd [4];
      exp_rd = '{32'd0, 32'd0, 32'd499999, 32'd255};
      reset = 1'b1;
      #2;
      checks++;
      if (out_port !== 4'h0) begin
         errors++;
         $display("FAIL reset_out_port: got %h expected 0", out_port);
      end
      for (int a = 0; a < 4; a++) begin
         address = 3'(a);
         #1;
         checks++;
         if (readdata !== exp_rd[a]) begin
            errors++;
            $display("FAIL reset_read addr%0d: got %0d expected %0d", a, readdata, exp_rd[a]);
         end
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_data_write();
      write_reg(3'd0, 32'hA);
      checks++;
      if (out_port !== 4'h0) begin
         errors++;
         $display("FAIL data_latency_early: got %h expected 0", out_port);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_port !== 4'hA) begin
         errors++;
         $display("FAIL data_out_port: got %h expected a", out_port);
      end
      address = 3'd0;
      #1;
      checks++;
      if (readdata !== 32'hA) begin
         errors++;
         $display("FAIL data_read: got %h expected a", readdata);
      end
   endtask

   task automatic test_set_clear();
      write_reg(3'd0, 32'h5);
      write_reg(3'd4, 32'h2);
      address = 3'd0;
      #1;
      checks++;
      if (readdata !== 32'h7) begin
         errors++;
         $display("FAIL outset: got %h expected 7", readdata);
      end
      write_reg(3'd5, 32'h4);
      address = 3'd0;
      #1;
      checks++;
      if (readdata !== 32'h3) begin
         errors++;
         $display("FAIL outclear: got %h expected 3", readdata);
      end
      for (int a = 4; a < 8; a = a + 1) begin
         if (a == 6) continue;
         address = 3'(a);
         #1;
         checks++;
         if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL wo_read addr%0d: got %h expected 0", a, readdata);
         end
      end
      write_reg(3'd0, 32'hFFFF_FFF0);
      address = 3'd0;
      #1;
      checks++;
      if (readdata !== 32'h0) begin
         errors++;
         $display("FAIL data_upper_ignored: got %h expected 0", readdata);
      end
      write_reg(3'd2, 32'hFFFF_FFFF);
      address = 3'd2;
      #1;
      checks++;
      if (readdata !== 32'h00FF_FFFF) begin
         errors++;
         $display("FAIL prescale_mask: got %h expected 00ffffff", readdata);
      end
   endtask

   task automatic test_blink();
      logic exp_out;
      logic exp_phase;
      write_reg(3'd0, 32'hF);
      write_reg(3'd1, 32'h1);
      write_reg(3'd3, 32'hFF);
      write_reg(3'd2, 32'h3);
      address = 3'd6;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         #1;
         exp_out   = ((k - 1) / 4) % 2 == 1;
         exp_phase = (k / 4) % 2 == 1;
         checks++;
         if (out_port !== {3'b111, exp_out}) begin
            errors++;
            $display("FAIL blink_out k=%0d: got %b expected %b", k, out_port, {3'b111, exp_out});
         end
         checks++;
         if (readdata[0] !== exp_phase) begin
            errors++;
            $display("FAIL blink_status k=%0d: got %b expected %b", k, readdata[0], exp_phase);
         end
      end
   endtask

   // Continues from test_blink: 16 edges after the PRESCALE=3 write, pre_cnt is 0.
   task automatic test_prescale_restart();
      logic exp_phase [4];
      exp_phase = '{1'b0, 1'b0, 1'b0, 1'b1};
      repeat (3) @(posedge clk);
      // Edge after this is where pre_cnt==3 would toggle the phase.
      write_reg(3'd2, 32'h2);
      address = 3'd6;
      checks++;
      if (readdata[0] !== 1'b0) begin
         errors++;
         $display("FAIL restart_no_toggle: got %b expected 0", readdata[0]);
      end
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (readdata[0] !== exp_phase[k]) begin
            errors++;
            $display("FAIL restart_phase k=%0d: got %b expected %b", k, readdata[0], exp_phase[k]);
         end
      end
   endtask

   task automatic test_pwm();
      logic [7:0] brights [3];
      int         exp_hi  [3];
      int         hi;
      brights = '{8'd64, 8'd0, 8'd255};
      exp_hi  = '{64, 0, 256};
      write_reg(3'd1, 32'h0);
      write_reg(3'd0, 32'h1);
      for (int b = 0; b < 3; b++) begin
         write_reg(3'd3, {24'd0, brights[b]});
         hi = 0;
         for (int c = 0; c < 256; c++) begin
            @(posedge clk);
            #1;
            if (out_port[0] === 1'b1) hi++;
         end
         checks++;
         if (hi !== exp_hi[b]) begin
            errors++;
            $display("FAIL pwm_bright%0d: got %0d high cycles expected %0d", brights[b], hi, exp_hi[b]);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0] exp_rd [4];
      int          waited;
      exp_rd = '{32'd0, 32'd0, 32'd499999, 32'd255};
      write_reg(3'd0, 32'hF);
      write_reg(3'd1, 32'h1);
      write_reg(3'd2, 32'h3);
      write_reg(3'd3, 32'd128);
      waited = 0;
      while (out_port === 4'h0 && waited < 600) begin
         @(posedge clk);
         #1;
         waited++;
      end
      checks++;
      if (out_port === 4'h0) begin
         errors++;
         $display("FAIL midreset_active: got %h expected nonzero before reset", out_port);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (out_port !== 4'h0) begin
         errors++;
         $display("FAIL midreset_out_port: got %h expected 0", out_port);
      end
      for (int a = 0; a < 4; a++) begin
         address = 3'(a);
         #0.5;
         checks++;
         if (readdata !== exp_rd[a]) begin
            errors++;
            $display("FAIL midreset_read addr%0d: got %0d expected %0d", a, readdata, exp_rd[a]);
         end
      end
      address = 3'd6;
      #0.5;
      checks++;
      if (readdata !== 32'h0) begin
         errors++;
         $display("FAIL midreset_status: got %h expected 0", readdata);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (out_port !== 4'h0) begin
         errors++;
         $display("FAIL postreset_out_port: got %h expected 0", out_port);
      end
   endtask

   initial begin
      reset      = 1'b1;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
      test_reset();
      test_data_write();
      test_set_clear();
      test_blink();
      test_prescale_restart();
      test_pwm();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
